// File: rtl/sound_seq.sv
// Note sequencer: queues {period, duration} pairs in a small FIFO and plays them one at a time
// by driving a registered tone value for duration * TICK_DIV clock cycles, with an optional gap.
module sound_seq #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 25000,
    parameter int unsigned GAP_CYC  = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic [15:0] wr_period,
    input  logic [15:0] wr_dur,
    input  logic        stop,
    output logic [15:0] tone,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_t;

    state_t        state_q, state_d;
    logic [15:0]   tone_q, tone_d;
    logic [15:0]   dur_q, dur_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   tick_q, tick_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ovf_q;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   cnt_q;

    logic [31:0]   head;
    logic [15:0]   head_period, head_dur;
    logic          fifo_full, fifo_empty;
    logic          do_push, do_pop;

    assign head        = mem_q[rd_ptr_q];
    assign head_period = head[31:16];
    assign head_dur    = head[15:0];
    assign fifo_full   = (cnt_q == CNT_FULL);
    assign fifo_empty  = (cnt_q == '0);

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign do_push = push && !stop && !fifo_full;

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
        do_pop  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tone_d = '0;
                if (!fifo_empty) state_d = StLoad;
            end
            StLoad: begin
                do_pop = 1'b1;
                pre_d  = '0;
                tick_d = '0;
                if (head_dur != '0) begin
                    state_d = StPlay;
                    tone_d  = head_period;
                    dur_d   = head_dur;
                end else begin
                    tone_d  = '0;
                    state_d = (cnt_q > CNT_ONE) ? StLoad : StIdle;
                end
            end
            StPlay: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (tick_q == dur_q - 16'd1) begin
                        tone_d = '0;
                        gap_d  = '0;
                        if (GAP_CYC > 0) state_d = StGap;
                        else             state_d = fifo_empty ? StIdle : StLoad;
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) state_d = fifo_empty ? StIdle : StLoad;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = StIdle;
        endcase

        if (stop) begin
            state_d = StIdle;
            tone_d  = '0;
            do_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            tone_q   <= '0;
            dur_q    <= '0;
            pre_q    <= '0;
            tick_q   <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            if (stop) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
                if (push && fifo_full) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_push) mem_q[wr_ptr_q] <= {wr_period, wr_dur};
    end

    assign tone  = tone_q;
    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign busy  = (state_q != StIdle);
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sound_seq.sv
// Bench for sound_seq: two instances (GAP_CYC=2 and GAP_CYC=0) share stimulus and are compared
// every cycle against a queue-and-duration reference model, plus directed scenario checks.
module tb_sound_seq;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;

    localparam int MI = 0;
    localparam int ML = 1;
    localparam int MP = 2;
    localparam int MG = 3;

    logic        clk = 1'b0;
    logic        resetn, push, stop;
    logic [15:0] wr_period, wr_dur;

    logic [15:0] tone_g, tone_n;
    logic        full_g, empty_g, busy_g, ovf_g;
    logic        full_n, empty_n, busy_n, ovf_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    sound_seq #(.DEPTH(DEPTH), .TICK_DIV(TICK), .GAP_CYC(2)) u_dut_gap (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .wr_period(wr_period),
        .wr_dur   (wr_dur),
        .stop     (stop),
        .tone     (tone_g),
        .full     (full_g),
        .empty    (empty_g),
        .busy     (busy_g),
        .ovf      (ovf_g)
    );

    sound_seq #(.DEPTH(DEPTH), .TICK_DIV(TICK), .GAP_CYC(0)) u_dut_nogap (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .wr_period(wr_period),
        .wr_dur   (wr_dur),
        .stop     (stop),
        .tone     (tone_n),
        .full     (full_n),
        .empty    (empty_n),
        .busy     (busy_n),
        .ovf      (ovf_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per instance, a circular note store plus a remaining-cycle budget.
    int          m_mode [2];
    int          m_cnt  [2];
    int          m_head [2];
    int          m_rem  [2];
    logic [15:0] m_tone [2];
    logic        m_ovf  [2];
    logic [15:0] m_per  [2][DEPTH];
    logic [15:0] m_dur  [2][DEPTH];
    int          mdl_n, mdl_idx, mdl_gap;
    logic [15:0] mdl_p, mdl_d;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            mdl_gap = (m == 0) ? 2 : 0;
            if (!resetn) begin
                m_mode[m] = MI; m_cnt[m] = 0; m_head[m] = 0; m_rem[m] = 0;
                m_tone[m] = '0; m_ovf[m] = 1'b0;
            end else if (stop) begin
                m_mode[m] = MI; m_cnt[m] = 0; m_tone[m] = '0; m_ovf[m] = 1'b0;
            end else begin
                mdl_n = m_cnt[m];
                if (push) begin
                    if (mdl_n == DEPTH) m_ovf[m] = 1'b1;
                    else begin
                        mdl_idx = (m_head[m] + mdl_n) % DEPTH;
                        m_per[m][mdl_idx] = wr_period;
                        m_dur[m][mdl_idx] = wr_dur;
                        m_cnt[m]++;
                    end
                end
                case (m_mode[m])
                    MI: if (mdl_n > 0) m_mode[m] = ML;
                    ML: begin
                        mdl_p = m_per[m][m_head[m]];
                        mdl_d = m_dur[m][m_head[m]];
                        m_head[m] = (m_head[m] + 1) % DEPTH;
                        m_cnt[m]--;
                        if (mdl_d != 0) begin
                            m_mode[m] = MP; m_tone[m] = mdl_p; m_rem[m] = int'(mdl_d) * TICK;
                        end else begin
                            m_tone[m] = '0; m_mode[m] = (mdl_n > 1) ? ML : MI;
                        end
                    end
                    MP: begin
                        m_rem[m]--;
                        if (m_rem[m] == 0) begin
                            m_tone[m] = '0;
                            if (mdl_gap > 0) begin m_mode[m] = MG; m_rem[m] = mdl_gap; end
                            else m_mode[m] = (mdl_n > 0) ? ML : MI;
                        end
                    end
                    default: begin
                        m_rem[m]--;
                        if (m_rem[m] == 0) m_mode[m] = (mdl_n > 0) ? ML : MI;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tone_gap",   32'(tone_g),  32'(m_tone[0]));
            check("full_gap",   32'(full_g),  32'(m_cnt[0] == DEPTH));
            check("empty_gap",  32'(empty_g), 32'(m_cnt[0] == 0));
            check("busy_gap",   32'(busy_g),  32'(m_mode[0] != MI));
            check("ovf_gap",    32'(ovf_g),   32'(m_ovf[0]));
            check("tone_nogap", 32'(tone_n),  32'(m_tone[1]));
            check("full_nogap", 32'(full_n),  32'(m_cnt[1] == DEPTH));
            check("empty_nogap",32'(empty_n), 32'(m_cnt[1] == 0));
            check("busy_nogap", 32'(busy_n),  32'(m_mode[1] != MI));
            check("ovf_nogap",  32'(ovf_n),   32'(m_ovf[1]));
        end
    end

    logic [15:0] seq [64];
    logic        bsy [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_note(input logic [15:0] p, input logic [15:0] d);
        push = 1'b1; wr_period = p; wr_dur = d;
        tick();
        push = 1'b0;
    endtask

    // seq[i] holds the output seen after the i-th edge following the call.
    task automatic record(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seq[i] = sel ? tone_n : tone_g;
            bsy[i] = sel ? busy_n : busy_g;
        end
        #1;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!busy_g && !busy_n && empty_g && empty_n) done = 1'b1;
            else tick();
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    function automatic int count_val(input logic [15:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (seq[i] == v) c++;
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_b, last_a, k;
        logic [15:0] order [8];
        logic [15:0] prev;

        resetn = 1'b0; push = 1'b0; stop = 1'b0; wr_period = '0; wr_dur = '0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_tone",  32'(tone_g),  32'd0);
        check("rst_empty", 32'(empty_g), 32'd1);
        check("rst_full",  32'(full_g),  32'd0);
        check("rst_busy",  32'(busy_g),  32'd0);
        check("rst_ovf",   32'(ovf_g),   32'd0);
        #1 resetn = 1'b1;
        tick();

        // Single note: latency, exact length, gap length.
        push_note(16'hFFFF, 16'd3);
        record(1'b0, 20);
        check("single_lat1",  32'(seq[1]), 32'd0);
        check("single_lat2",  32'(seq[2]), 32'hFFFF);
        check("single_len",   32'(count_val(16'hFFFF, 20)), 32'd12);
        check("single_end",   32'(seq[14]), 32'd0);
        check("single_gap_b", 32'(bsy[15]), 32'd1);
        check("single_idle",  32'(bsy[16]), 32'd0);
        wait_idle();

        // Back-to-back queue on the no-gap instance.
        push_note(16'hFFFF, 16'd1);
        push_note(16'hFFFD, 16'd2);
        record(1'b1, 20);
        check("queue_len1", 32'(count_val(16'hFFFF, 20)), 32'd4);
        check("queue_len2", 32'(count_val(16'hFFFD, 20)), 32'd8);
        last_a = -1; first_b = -1;
        for (int i = 0; i < 20; i++) begin
            if (seq[i] == 16'hFFFF) last_a = i;
            if (seq[i] == 16'hFFFD && first_b < 0) first_b = i;
        end
        check("queue_sep", 32'(first_b - last_a - 1), 32'd1);
        wait_idle();
        check("queue_empty", 32'(empty_n), 32'd1);

        // Overflow while the first note is held in PLAY.
        push_note(16'd1, 16'd3);
        tick(); tick();
        for (int i = 0; i < 5; i++) push_note(16'(11 + i), 16'd1);
        @(negedge clk);
        check("ovf_full", 32'(full_g), 32'd1);
        check("ovf_flag", 32'(ovf_g),  32'd1);
        #1;
        record(1'b0, 60);
        k = 0; prev = '0;
        for (int i = 0; i < 60; i++) begin
            if (seq[i] != 0 && seq[i] != prev && k < 8) begin order[k] = seq[i]; k++; end
            prev = seq[i];
        end
        check("ovf_count", 32'(k), 32'd5);
        for (int i = 0; i < 5 && i < k; i++)
            check("ovf_order", 32'(order[i]), (i == 0) ? 32'd1 : 32'(10 + i));
        wait_idle();

        // Zero-duration entry is discarded.
        push_note(16'd7, 16'd0);
        push_note(16'd9, 16'd1);
        record(1'b0, 20);
        check("zero_never", 32'(count_val(16'd7, 20)), 32'd0);
        check("zero_next",  32'(count_val(16'd9, 20)), 32'd4);
        wait_idle();

        // Stop with a same-cycle push, after forcing overflow.
        push_note(16'd5, 16'd3);
        tick(); tick();
        for (int i = 0; i < 5; i++) push_note(16'(21 + i), 16'd1);
        stop = 1'b1; push = 1'b1; wr_period = 16'h0077; wr_dur = 16'd1;
        tick();
        stop = 1'b0; push = 1'b0;
        @(negedge clk);
        check("stop_tone",  32'(tone_g),  32'd0);
        check("stop_empty", 32'(empty_g), 32'd1);
        check("stop_busy",  32'(busy_g),  32'd0);
        check("stop_ovf",   32'(ovf_g),   32'd0);
        #1;
        record(1'b0, 20);
        check("stop_drop", 32'(count_val(16'h0077, 20)), 32'd0);

        // Reset in the middle of a note, with a push during reset.
        push_note(16'h8001, 16'd3);
        repeat (5) tick();
        resetn = 1'b0; push = 1'b1; wr_period = 16'h0055; wr_dur = 16'd2;
        tick();
        resetn = 1'b1; push = 1'b0;
        @(negedge clk);
        check("rmid_tone",  32'(tone_g),  32'd0);
        check("rmid_empty", 32'(empty_g), 32'd1);
        check("rmid_busy",  32'(busy_g),  32'd0);
        check("rmid_ovf",   32'(ovf_g),   32'd0);
        check("rmid_full",  32'(full_g),  32'd0);
        #1;
        push_note(16'h4242, 16'd1);
        record(1'b1, 12);
        check("rmid_replay", 32'(count_val(16'h4242, 12)), 32'd4);
        check("rmid_nodrop", 32'(count_val(16'h0055, 12)), 32'd0);
        wait_idle();

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 1500; c++) begin
            push      = ($urandom_range(0, 3) == 0);
            wr_period = 16'($urandom);
            wr_dur    = 16'($urandom_range(0, 3));
            stop      = ($urandom_range(0, 99) == 0);
            resetn    = ($urandom_range(0, 299) != 0);
            tick();
        end
        push = 1'b0; stop = 1'b0; resetn = 1'b1;
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
